// File: rtl/fifo_stream_reader_if.sv
// Wide output stream of fifo_stream_reader: valid/ready beat with per-word keep
// mask and packet-end marker.
interface fifo_stream_reader_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PACK  = 4
);
  logic                  m_valid;
  logic                  m_ready;
  logic [WIDTH*PACK-1:0] m_data;
  logic [PACK-1:0]       m_keep;
  logic                  m_last;

  modport master (
    output m_valid,
    output m_data,
    output m_keep,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_keep,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a show-ahead FIFO read port, packs PACK words per output beat, tags
// every BURST-th beat with m_last and supports flushing a partial beat.
module fifo_stream_reader #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned PACK  = 4,
  parameter int unsigned BURST = 4
) (
  input  logic             rclk,
  input  logic             rstn,
  input  logic             empty,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic             pop,
  input  logic             flush,
  output logic             busy,
  fifo_stream_reader_if.master m
);

  localparam int unsigned CNT_W  = $clog2(PACK) + 1;
  localparam int unsigned BCNT_W = $clog2(BURST) + 1;
  localparam logic [CNT_W-1:0]  LAST_SLOT = CNT_W'(PACK - 1);
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BCNT_W-1:0]     bcnt_q, bcnt_d;
  logic [WIDTH*PACK-1:0] pack_q, pack_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  m_valid_q, m_valid_d;
  logic [WIDTH*PACK-1:0] m_data_q, m_data_d;
  logic [PACK-1:0]       m_keep_q, m_keep_d;
  logic                  m_last_q, m_last_d;

  logic                  out_free;
  logic                  pop_last;
  logic                  flush_load;
  logic                  beat_last;
  logic [WIDTH*PACK-1:0] pack_w;
  logic [PACK-1:0]       keep_mask;

  assign out_free   = !m_valid_q || m.m_ready;
  // Pending flush blocks pops so the partial beat is exactly what was held.
  assign pop        = rstn && !empty && !flush_pend_q && ((cnt_q < LAST_SLOT) || out_free);
  assign pop_last   = pop && (cnt_q == LAST_SLOT);
  assign flush_load = flush_pend_q && (cnt_q != '0) && out_free;

  always_comb begin
    pack_w    = pack_q;
    keep_mask = '0;
    for (int unsigned i = 0; i < PACK; i++) begin
      if (pop && (CNT_W'(i) == cnt_q)) pack_w[i*WIDTH +: WIDTH] = fifo_dout;
      keep_mask[i] = (CNT_W'(i) < cnt_q);
    end
  end

  always_comb begin
    cnt_d        = cnt_q;
    bcnt_d       = bcnt_q;
    pack_d       = pack_w;
    flush_pend_d = flush_pend_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_last_d     = m_last_q;
    beat_last    = 1'b0;

    if (m_valid_q && m.m_ready) m_valid_d = 1'b0;
    if (pop) cnt_d = cnt_q + CNT_W'(1);

    // Slots are zeroed on every beat load, so a partial beat's unfilled
    // slots already read as zero.
    if (pop_last || flush_load) begin
      beat_last = flush_load || flush || (bcnt_q == LAST_BEAT);
      m_valid_d = 1'b1;
      m_data_d  = pack_w;
      m_keep_d  = pop_last ? '1 : keep_mask;
      m_last_d  = beat_last;
      bcnt_d    = beat_last ? '0 : bcnt_q + BCNT_W'(1);
      pack_d    = '0;
      cnt_d     = '0;
    end

    if (flush_pend_q && ((cnt_q == '0) || flush_load)) flush_pend_d = 1'b0;
    // A flush landing on a full-beat completion is folded into that beat.
    if (flush && !pop_last) flush_pend_d = 1'b1;
  end

  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      bcnt_q       <= '0;
      pack_q       <= '0;
      flush_pend_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_keep_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bcnt_q       <= bcnt_d;
      pack_q       <= pack_d;
      flush_pend_q <= flush_pend_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_last_q     <= m_last_d;
    end
  end

  assign m.m_valid = m_valid_q;
  assign m.m_data  = m_data_q;
  assign m.m_keep  = m_keep_q;
  assign m.m_last  = m_last_q;
  assign busy      = (cnt_q != '0) || m_valid_q || flush_pend_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: queue-based FIFO and beat model.
module tb_fifo_stream_reader;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PACK  = 4;
  localparam int unsigned BURST = 4;

  typedef struct {
    logic [WIDTH*PACK-1:0] data;
    logic [PACK-1:0]       keep;
    logic                  last;
  } beat_t;

  logic             rclk;
  logic             rstn;
  logic             empty;
  logic [WIDTH-1:0] fifo_dout;
  logic             pop;
  logic             flush;
  logic             busy;

  fifo_stream_reader_if #(.WIDTH(WIDTH), .PACK(PACK)) s_if ();

  fifo_stream_reader #(.WIDTH(WIDTH), .PACK(PACK), .BURST(BURST)) dut (
    .rclk      (rclk),
    .rstn      (rstn),
    .empty     (empty),
    .fifo_dout (fifo_dout),
    .pop       (pop),
    .flush     (flush),
    .busy      (busy),
    .m         (s_if.master)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  int unsigned tests = 0;
  int unsigned fails = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] stage[$];
  beat_t            exp_q[$];
  int unsigned      model_bcnt = 0;
  int unsigned      pop_cnt = 0;
  logic             gate = 1'b0;

  logic                  stall_prev = 1'b0;
  logic [WIDTH*PACK-1:0] prev_data;
  logic [PACK-1:0]       prev_keep;
  logic                  prev_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic emit_beat(input logic partial);
    beat_t b;
    b.data = '0;
    b.keep = '0;
    for (int i = 0; i < stage.size(); i++) begin
      b.data[i*WIDTH +: WIDTH] = stage[i];
      b.keep[i] = 1'b1;
    end
    b.last = partial || (model_bcnt == BURST - 1);
    model_bcnt = b.last ? 0 : model_bcnt + 1;
    exp_q.push_back(b);
    stage.delete();
  endtask

  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    stage.push_back(w);
    if (stage.size() == PACK) emit_beat(1'b0);
  endtask

  task automatic flush_model();
    if (stage.size() > 0) emit_beat(1'b1);
  endtask

  task automatic refresh();
    empty     = gate || (fifo_q.size() == 0);
    fifo_dout = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  task automatic tick();
    logic s_pop;
    beat_t b;
    refresh();
    @(negedge rclk);
    s_pop = pop;
    if (s_pop) begin
      check("pop_nonempty", {63'd0, empty}, 64'd0);
      pop_cnt++;
    end
    if (stall_prev) begin
      check("stall_valid", {63'd0, s_if.m_valid}, 64'd1);
      check("stall_data", {32'd0, s_if.m_data}, {32'd0, prev_data});
      check("stall_keep", {60'd0, s_if.m_keep}, {60'd0, prev_keep});
      check("stall_last", {63'd0, s_if.m_last}, {63'd0, prev_last});
    end
    stall_prev = s_if.m_valid && !s_if.m_ready;
    prev_data  = s_if.m_data;
    prev_keep  = s_if.m_keep;
    prev_last  = s_if.m_last;
    if (s_if.m_valid && s_if.m_ready) begin
      check("beat_pending", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0) begin
        b = exp_q.pop_front();
        check("beat_data", {32'd0, s_if.m_data}, {32'd0, b.data});
        check("beat_keep", {60'd0, s_if.m_keep}, {60'd0, b.keep});
        check("beat_last", {63'd0, s_if.m_last}, {63'd0, b.last});
      end
    end
    @(posedge rclk);
    #1;
    if (s_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
    flush = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) tick();
    tick();
    tick();
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rstn         = 1'b0;
    flush        = 1'b0;
    s_if.m_ready = 1'b0;
    fifo_q.push_back(8'h55);
    refresh();
    #2;
    check("rst_valid", {63'd0, s_if.m_valid}, 64'd0);
    check("rst_data", {32'd0, s_if.m_data}, 64'd0);
    check("rst_keep", {60'd0, s_if.m_keep}, 64'd0);
    check("rst_last", {63'd0, s_if.m_last}, 64'd0);
    check("rst_pop", {63'd0, pop}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    tick();
    tick();
    fifo_q.delete();
    rstn = 1'b1;
    tick();

    // Streaming at full rate
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) push_word(8'(i));
    pop_cnt = 0;
    for (int i = 0; i < 16; i++) tick();
    check("t1_pops", 64'(pop_cnt), 64'd16);
    drain("t1_drain", 50);

    // Output stalled: three extra words absorbed, fourth held
    s_if.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(i));
    pop_cnt = 0;
    for (int i = 0; i < 10; i++) tick();
    check("t2_pops", 64'(pop_cnt), 64'd7);
    check("t2_valid", {63'd0, s_if.m_valid}, 64'd1);
    s_if.m_ready = 1'b1;
    drain("t2_drain", 50);

    // Partial beat via flush, then a full beat with restarted counter
    push_word(8'hA1);
    push_word(8'hA2);
    tick();
    tick();
    flush = 1'b1;
    flush_model();
    tick();
    drain("t3_flush_drain", 50);
    for (int i = 0; i < 4; i++) push_word(8'(8'hC0 + i));
    drain("t3_full_drain", 50);

    // Flush with nothing held
    flush = 1'b1;
    flush_model();
    tick();
    check("t4_busy_pend", {63'd0, busy}, 64'd1);
    tick();
    check("t4_busy_idle", {63'd0, busy}, 64'd0);
    check("t4_novalid", {63'd0, s_if.m_valid}, 64'd0);

    // Flush together with the third pop
    push_word(8'hB1);
    push_word(8'hB2);
    push_word(8'hB3);
    tick();
    tick();
    flush = 1'b1;
    flush_model();
    tick();
    drain("t4_flush3_drain", 50);

    // Reset mid-packet with a stalled beat
    s_if.m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h20 + i));
    for (int i = 0; i < 8; i++) tick();
    fifo_q.push_back(8'h26);
    refresh();
    #1;
    check("t5_pop_before", {63'd0, pop}, 64'd1);
    check("t5_valid_before", {63'd0, s_if.m_valid}, 64'd1);
    rstn = 1'b0;
    #1;
    check("t5_pop_rst", {63'd0, pop}, 64'd0);
    check("t5_valid_rst", {63'd0, s_if.m_valid}, 64'd0);
    check("t5_keep_rst", {60'd0, s_if.m_keep}, 64'd0);
    check("t5_busy_rst", {63'd0, busy}, 64'd0);
    fifo_q.delete();
    stage.delete();
    model_bcnt = 0;
    stall_prev = 1'b0;
    tick();
    rstn = 1'b1;
    s_if.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(8'(8'h10 + i));
    drain("t5_drain", 50);

    // Random FIFO availability and downstream backpressure
    for (int i = 0; i < 1000; i++) push_word(8'($urandom_range(0, 255)));
    for (int c = 0; c < 20000 && exp_q.size() > 0; c++) begin
      gate         = ($urandom_range(0, 99) < 30);
      s_if.m_ready = ($urandom_range(0, 99) < 70);
      tick();
    end
    gate         = 1'b0;
    s_if.m_ready = 1'b1;
    drain("rand_drain", 50);
    check("rand_fifo_empty", 64'(fifo_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
